priority_request_capture: RTL and testbench
===========================================

# priority_request_capture

Upstream input-conditioning stage for the 8-bit priority encoder / 7-segment display path. It synchronises and debounces eight raw request inputs and sticky-latches each debounced rising edge as a pending request. The `pending` vector drives the encoder's `data` input directly. Consumers retire a request by index once it has been displayed or served, and the block flags any event lost to an already-pending request.

## Interface
- `DEBOUNCE_CYCLES`, default 1000: consecutive cycles a synchronised input must differ from its debounced level before the level flips. Legal range is 1 to 65535; counter width is the ceiling of log2(`DEBOUNCE_CYCLES`+1).
- `clk` in 1: single clock for all state.
- `rst` in 1: synchronous, active-high reset.
- `req_raw` in 8: asynchronous raw request pins. Bit 7 is the highest priority downstream.
- `clr_valid` in 1: single-cycle strobe that clears one request.
- `clr_idx` in 3: index of the request to clear. Qualified by `clr_valid`.
- `clr_all` in 1: clears all pending and overrun bits.
- `level` out 8: debounced input levels.
- `pending` out 8: sticky pending requests, fed to the encoder `data` input.
- `overrun` out 8: sticky flag per channel, set when a rising edge arrives while that channel is already pending.
- `any_pending` out 1: OR of `pending`, registered-equivalent because it is derived only from flops.

## Operation
- **Per channel `i`:**
  - A 2-flop synchroniser produces `s[i]`.
  - A counter `cnt[i]` resets to 0 whenever `s[i]` equals `level[i]`, and increments while they differ.
  - When `s[i]` differs from `level[i]` and `cnt[i]` equals `DEBOUNCE_CYCLES`-1, the next edge toggles `level[i]` and zeroes `cnt[i]`.
  - Any glitch shorter than `DEBOUNCE_CYCLES` synchronised cycles is discarded.
- **Rising edge event:** occurs on the edge where `level[i]` goes 0→1. On that edge `pending[i]` is set. If `pending[i]` was already 1, `overrun[i]` is set as well. Falling edges never affect `pending`.
- **Clear:**
  - `clr_valid` clears `pending[clr_idx]` and `overrun[clr_idx]` on the next edge.
  - `clr_all` clears all bits.
  - `clr_all` together with `clr_valid` behaves the same as `clr_all` alone.
- **Simultaneous set and clear on the same bit:** set wins. `pending` stays 1 and `overrun` is not set.
- **Independence:** clears and sets on different bits in the same cycle are independent.
- **Reset:** synchronisers, counters, `level`, `pending` and `overrun` all go to 0, so every output is 0. An input held high through reset is re-debounced afterwards and produces exactly one new pending event.
- **Clearing a held input:** clearing a request while its input is still held high does not re-set it. Only a new 0→1 debounced transition sets it again.

## Timing
- **Latency:** if a raw input is stable from the edge at cycle t, `s` changes after edge t+2 and `level` or `pending` changes at edge t+2+`DEBOUNCE_CYCLES`. Total latency is 2+`DEBOUNCE_CYCLES` clocks.
- **Output registration:** all outputs are registered. `any_pending` may be a combinational OR of the `pending` flops.
- **Clear latency:** 1 cycle. `pending` reads 0 in the cycle after the `clr_valid` edge.
- **No handshake backpressure:** `clr_valid` is a fire-and-forget strobe, and clearing a bit that is already 0 is a no-op.
- **Counter saturation:** not reachable, because the counter resets at the threshold.

## Structure
- **Package `prio_input_pkg`:**
  - `NUM_CH` = 8.
  - `ch_idx_t` = 3-bit index type.
  - A function computing the counter width from `DEBOUNCE_CYCLES`.
- **Sub-module `debounce_channel`:** contains the synchroniser, counter and `level` flop, and outputs `level` plus a one-cycle `rise` pulse. It is instantiated `NUM_CH` times.
- **Top level:** holds the `pending`/`overrun` register bank and the clear decode.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4.
- **Clean press:** `req_raw`=0x20 applied at cycle 0 and held → `level`=0x20 and `pending`=0x20 at cycle 6, `any_pending`=1, `overrun`=0x00.
- **Glitch rejection:** `req_raw[3]` high for 3 cycles then low → `level` and `pending` stay 0x00 throughout.
- **Overrun and clear:** pulse bit 1 long enough to register, release, then pulse it again → `pending`=0x02 and `overrun`=0x02. Then `clr_valid`=1 with `clr_idx`=1 → next cycle `pending`=0x00 and `overrun`=0x00.
- **Set beats clear:** `clr_valid`/`clr_idx`=7 asserted on the same edge that `level[7]` rises → `pending[7]`=1 and `overrun[7]`=0.
- **Multi-channel and clear_all:** `req_raw`=0x81 → `pending`=0x81. Then `clr_all` → `pending`=0x00 while `level` stays 0x81, and no re-set occurs while the inputs are held.
- **Reset mid-operation:** `req_raw`=0x10 held, `pending`=0x10, then `rst` asserted for 1 cycle → all outputs 0x00. `pending`=0x10 again 6 cycles after `rst` deasserts.

Source files
------------

// File: rtl/priority_request_capture_pkg.sv
// prio_input_pkg: channel count, channel index type and debounce counter width helper
package prio_input_pkg;
  localparam int NUM_CH = 8;
  typedef logic [2:0] ch_idx_t;
  function automatic int cnt_width(input int debounce_cycles);
    return $clog2(debounce_cycles + 1);
  endfunction
endpackage

// File: rtl/priority_request_capture_if.sv
// priority_request_capture_if: raw requests and clears in; level, pending, overrun, any_pending out
interface priority_request_capture_if;
  import prio_input_pkg::*;
  logic [NUM_CH-1:0] req_raw;
  logic clr_valid;
  ch_idx_t clr_idx;
  logic clr_all;
  logic [NUM_CH-1:0] level;
  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] overrun;
  logic any_pending;
  modport master (output req_raw, clr_valid, clr_idx, clr_all, input level, pending, overrun, any_pending);
  modport slave (input req_raw, clr_valid, clr_idx, clr_all, output level, pending, overrun, any_pending);
endinterface

// File: rtl/priority_request_capture_debounce_channel.sv
// debounce_channel: clk/rst, raw in; 2-flop sync + counter debounce, level out and comb rise on the edge level goes 0->1
module debounce_channel
  import prio_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);
  localparam int W = cnt_width(DEBOUNCE_CYCLES);
  logic [1:0] sync;
  logic [W-1:0] cnt;
  logic s;
  logic flip;
  assign s = sync[1];
  assign flip = (s != level) && (cnt == W'(DEBOUNCE_CYCLES - 1));
  assign rise = flip && !level;
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      cnt <= '0;
      level <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      cnt <= (s == level || flip) ? '0 : cnt + 1'b1;
      level <= flip ? ~level : level;
    end
  end
endmodule

// File: rtl/priority_request_capture.sv
// priority_request_capture: clk/rst plus bus (req_raw, clr_valid, clr_idx, clr_all in; level, pending, overrun, any_pending out)
module priority_request_capture
  import prio_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input logic clk,
  input logic rst,
  priority_request_capture_if.slave bus
);
  logic [NUM_CH-1:0] level;
  logic [NUM_CH-1:0] rise;
  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] overrun;
  logic [NUM_CH-1:0] clr_mask;
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ch (
      .clk(clk),
      .rst(rst),
      .raw(bus.req_raw[g]),
      .level(level[g]),
      .rise(rise[g])
    );
  end
  always_comb begin
    clr_mask = bus.clr_all ? '1 : bus.clr_valid ? NUM_CH'(1) << bus.clr_idx : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      overrun <= '0;
    end else begin
      pending <= rise | (pending & ~clr_mask);
      overrun <= (overrun | (rise & pending)) & ~clr_mask;
    end
  end
  assign bus.level = level;
  assign bus.pending = pending;
  assign bus.overrun = overrun;
  assign bus.any_pending = |pending;
endmodule

// File: tb/tb_priority_request_capture.sv
// tb_priority_request_capture: randomized and directed checks against a history-based reference model
module tb_priority_request_capture;
  import prio_input_pkg::*;
  localparam int D = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  priority_request_capture_if bus ();
  priority_request_capture #(.DEBOUNCE_CYCLES(D)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  // Model: a channel flips when the last D synchronised samples (raw delayed two edges) all differ from its level.
  logic [7:0] hist[$];
  logic [7:0] m_level = '0, m_pend = '0, m_ovr = '0;
  always @(posedge clk) begin
    logic [7:0] rise_v, cm, hv;
    logic all_diff;
    while (hist.size() < D + 2) hist.push_back('0);
    if (rst) begin
      foreach (hist[k]) hist[k] = '0;
      hist.push_front('0);
      m_level = '0;
      m_pend = '0;
      m_ovr = '0;
    end else begin
      hist.push_front(bus.req_raw);
      rise_v = '0;
      for (int i = 0; i < 8; i++) begin
        all_diff = 1'b1;
        for (int j = 0; j < D; j++) begin
          hv = hist[2 + j];
          if (hv[i] == m_level[i]) all_diff = 1'b0;
        end
        if (all_diff) begin
          m_level[i] = ~m_level[i];
          rise_v[i] = m_level[i];
        end
      end
      cm = '0;
      if (bus.clr_all) cm = 8'hFF;
      else if (bus.clr_valid) cm[bus.clr_idx] = 1'b1;
      for (int i = 0; i < 8; i++) begin
        if (rise_v[i]) begin
          if (m_pend[i] && !cm[i]) m_ovr[i] = 1'b1;
          if (cm[i]) m_ovr[i] = 1'b0;
          m_pend[i] = 1'b1;
        end else if (cm[i]) begin
          m_pend[i] = 1'b0;
          m_ovr[i] = 1'b0;
        end
      end
    end
    while (hist.size() > D + 2) void'(hist.pop_back());
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_raw = '0;
    bus.clr_valid = 1'b0;
    bus.clr_idx = '0;
    bus.clr_all = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_raw = 8'($urandom);
    bus.clr_valid = 1'b0;
    bus.clr_idx = '0;
    bus.clr_all = 1'b0;
    tick();
    tick();
    checks++;
    if ({bus.level, bus.pending, bus.overrun, bus.any_pending} !== 25'd0) begin
      failures++;
      $display("FAIL reset: got level=%h pending=%h overrun=%h any=%b want all 0", bus.level, bus.pending, bus.overrun, bus.any_pending);
    end
    rst = 1'b0;
    bus.req_raw = '0;
  endtask

  task automatic test_clean_press();
    do_reset();
    bus.req_raw = 8'h20;
    for (int c = 1; c <= 8; c++) begin
      tick();
      checks++;
      if ({bus.level, bus.pending, bus.overrun, bus.any_pending} !== {m_level, m_pend, m_ovr, |m_pend}) begin
        failures++;
        $display("FAIL clean_press_model c=%0d: got %h/%h/%h/%b want %h/%h/%h/%b", c, bus.level, bus.pending, bus.overrun, bus.any_pending, m_level, m_pend, m_ovr, |m_pend);
      end
      if (c == 5) begin
        checks++;
        if (bus.level !== 8'h00 || bus.pending !== 8'h00) begin
          failures++;
          $display("FAIL clean_press_early: got level=%h pending=%h want 00/00", bus.level, bus.pending);
        end
      end
      if (c == 6) begin
        checks++;
        if ({bus.level, bus.pending, bus.overrun, bus.any_pending} !== {8'h20, 8'h20, 8'h00, 1'b1}) begin
          failures++;
          $display("FAIL clean_press: got level=%h pending=%h overrun=%h any=%b want 20/20/00/1", bus.level, bus.pending, bus.overrun, bus.any_pending);
        end
      end
    end
  endtask

  task automatic test_glitch();
    do_reset();
    bus.req_raw = 8'h08;
    for (int c = 1; c <= 12; c++) begin
      if (c == 4) bus.req_raw = 8'h00;
      tick();
      checks++;
      if (bus.level !== 8'h00 || bus.pending !== 8'h00) begin
        failures++;
        $display("FAIL glitch c=%0d: got level=%h pending=%h want 00/00", c, bus.level, bus.pending);
      end
    end
  endtask

  task automatic test_overrun_clear();
    do_reset();
    bus.req_raw = 8'h02;
    repeat (8) tick();
    bus.req_raw = 8'h00;
    repeat (8) tick();
    bus.req_raw = 8'h02;
    repeat (8) tick();
    checks++;
    if (bus.pending !== 8'h02 || bus.overrun !== 8'h02) begin
      failures++;
      $display("FAIL overrun: got pending=%h overrun=%h want 02/02", bus.pending, bus.overrun);
    end
    bus.clr_valid = 1'b1;
    bus.clr_idx = 3'd1;
    tick();
    bus.clr_valid = 1'b0;
    checks++;
    if (bus.pending !== 8'h00 || bus.overrun !== 8'h00 || bus.any_pending !== 1'b0) begin
      failures++;
      $display("FAIL clear_idx: got pending=%h overrun=%h any=%b want 00/00/0", bus.pending, bus.overrun, bus.any_pending);
    end
    repeat (6) tick();
    checks++;
    if (bus.pending !== 8'h00 || bus.level !== 8'h02) begin
      failures++;
      $display("FAIL clear_held: got pending=%h level=%h want 00/02", bus.pending, bus.level);
    end
  endtask

  task automatic test_set_beats_clear();
    do_reset();
    bus.req_raw = 8'h80;
    repeat (5) tick();
    bus.clr_valid = 1'b1;
    bus.clr_idx = 3'd7;
    tick();
    bus.clr_valid = 1'b0;
    checks++;
    if (bus.level !== 8'h80 || bus.pending !== 8'h80 || bus.overrun !== 8'h00) begin
      failures++;
      $display("FAIL set_beats_clear: got level=%h pending=%h overrun=%h want 80/80/00", bus.level, bus.pending, bus.overrun);
    end
  endtask

  task automatic test_multi_clear_all();
    do_reset();
    bus.req_raw = 8'h81;
    repeat (8) tick();
    checks++;
    if (bus.pending !== 8'h81) begin
      failures++;
      $display("FAIL multi: got pending=%h want 81", bus.pending);
    end
    bus.clr_all = 1'b1;
    bus.clr_valid = 1'b1;
    bus.clr_idx = 3'd3;
    tick();
    bus.clr_all = 1'b0;
    bus.clr_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (bus.pending !== 8'h00 || bus.level !== 8'h81) begin
        failures++;
        $display("FAIL clear_all c=%0d: got pending=%h level=%h want 00/81", c, bus.pending, bus.level);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.req_raw = 8'h10;
    repeat (8) tick();
    checks++;
    if (bus.pending !== 8'h10) begin
      failures++;
      $display("FAIL reset_mid_pre: got pending=%h want 10", bus.pending);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({bus.level, bus.pending, bus.overrun, bus.any_pending} !== 25'd0) begin
      failures++;
      $display("FAIL reset_mid: got level=%h pending=%h overrun=%h any=%b want all 0", bus.level, bus.pending, bus.overrun, bus.any_pending);
    end
    repeat (5) tick();
    checks++;
    if (bus.pending !== 8'h00) begin
      failures++;
      $display("FAIL reset_mid_early: got pending=%h want 00", bus.pending);
    end
    tick();
    checks++;
    if (bus.pending !== 8'h10 || bus.overrun !== 8'h00) begin
      failures++;
      $display("FAIL reset_mid_post: got pending=%h overrun=%h want 10/00", bus.pending, bus.overrun);
    end
  endtask

  task automatic test_random();
    logic [7:0] r;
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      r = bus.req_raw;
      for (int i = 0; i < 8; i++) if ($urandom_range(7) == 0) r[i] = ~r[i];
      bus.req_raw = r;
      bus.clr_valid = ($urandom_range(5) == 0);
      bus.clr_idx = 3'($urandom);
      bus.clr_all = ($urandom_range(60) == 0);
      rst = ($urandom_range(400) == 0);
      tick();
      checks++;
      if ({bus.level, bus.pending, bus.overrun, bus.any_pending} !== {m_level, m_pend, m_ovr, |m_pend}) begin
        failures++;
        $display("FAIL random c=%0d: got %h/%h/%h/%b want %h/%h/%h/%b", c, bus.level, bus.pending, bus.overrun, bus.any_pending, m_level, m_pend, m_ovr, |m_pend);
      end
    end
    rst = 1'b0;
    bus.clr_valid = 1'b0;
    bus.clr_all = 1'b0;
  endtask

  initial begin
    bus.req_raw = '0;
    bus.clr_valid = 1'b0;
    bus.clr_idx = '0;
    bus.clr_all = 1'b0;
    test_reset();
    test_clean_press();
    test_glitch();
    test_overrun_clear();
    test_set_beats_clear();
    test_multi_clear_all();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
